piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_tx.sv | 70 +++++++
 tb/tb_piso_tx.sv | 130 +++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, MSB first, valid/ready on both sides.
// Define PISO_TX_PARITY_EN to append an even-parity bit after each word.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  state_t state, state_n;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0] cnt;
  logic load_hs, bit_hs, last, fin, done_r;
  assign load_ready = state == IDLE;
  assign load_hs = load_ready && load_valid;
  assign bit_hs = ser_valid && ser_ready;
  assign last = state == SHIFT && bit_hs && cnt == CW'(WIDTH - 1);
  assign done = done_r;
`ifdef PISO_TX_PARITY_EN
  logic par;
  assign ser_valid = state != IDLE;
  assign ser_out = state == SHIFT ? shreg[WIDTH-1] : (state == PARITY) && par;
  assign fin = state == PARITY && bit_hs;
  always_comb begin
    state_n = state;
    state_n = load_hs ? SHIFT : last ? PARITY : fin ? IDLE : state;
  end
  // parity is taken from the word as loaded, so later changes on d cannot leak in
  always_ff @(posedge clk or posedge rst)
    if (rst) par <= 1'b0;
    else if (load_hs) par <= ^d;
`else
  assign ser_valid = state == SHIFT;
  assign ser_out = (state == SHIFT) && shreg[WIDTH-1];
  assign fin = last;
  always_comb begin
    state_n = state;
    state_n = load_hs ? SHIFT : last ? IDLE : state;
  end
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      done_r <= 1'b0;
    end else begin
      state <= state_n;
      done_r <= fin;
      if (load_hs) begin
        shreg <= d;
        cnt <= '0;
      end else if (state == SHIFT && bit_hs) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed and randomized checks of piso_tx against a bit-stream reference model.
module tb_piso_tx;
  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  logic clk = 1'b0, rst = 1'b1, load_valid = 1'b0, ser_ready = 1'b0;
  logic load_ready, ser_out, ser_valid, done;
  logic [W-1:0] d = '0;
  int total = 0, fails = 0;

  piso_tx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .d(d), .ser_out(ser_out), .ser_valid(ser_valid), .ser_ready(ser_ready), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference: the i-th serial bit of word w is its (W-1-i)-th bit, then the word's even parity.
  function automatic logic ref_bit(input logic [W-1:0] w, input int i);
    int v;
    v = int'(w);
    return (i < W) ? logic'((v >> (W - 1 - i)) & 1) : ^w;
  endfunction

  task automatic idle_chk(input string tag, input logic exp_done);
    chk({tag, "_ready"}, load_ready, 1'b1);
    chk({tag, "_valid"}, ser_valid, 1'b0);
    chk({tag, "_out"}, ser_out, 1'b0);
    chk({tag, "_done"}, done, exp_done);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int smax, input int sat,
                           input int slen, input logic rnd, input logic [W-1:0] jd);
    int st;
    logic e;
    chk("pre_load_ready", load_ready, 1'b1);
    chk("pre_load_valid", ser_valid, 1'b0);
    load_valid = 1'b1;
    d = w;
    ser_ready = 1'($urandom);
    step();
    for (int i = 0; i < NB; i++) begin
      e = ref_bit(w, i);
      st = (i == sat) ? slen : int'($urandom_range(smax, 0));
      for (int s = 0; s < st; s++) begin
        load_valid = 1'b1;
        d = rnd ? W'($urandom) : jd;
        ser_ready = 1'b0;
        chk("stall_valid", ser_valid, 1'b1);
        chk("stall_out", ser_out, e);
        chk("stall_ready", load_ready, 1'b0);
        chk("stall_done", done, 1'b0);
        step();
      end
      load_valid = 1'b1;
      d = rnd ? W'($urandom) : jd;
      ser_ready = 1'b1;
      chk("bit_valid", ser_valid, 1'b1);
      chk("bit_out", ser_out, e);
      chk("bit_ready", load_ready, 1'b0);
      chk("bit_done", done, 1'b0);
      step();
    end
    load_valid = 1'b0;
    ser_ready = 1'($urandom);
    idle_chk("word_end", 1'b1);
  endtask

  task automatic gap(input int n);
    load_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      idle_chk("gap", 1'b0);
    end
  endtask

  initial begin
    #2;
    idle_chk("rst_async", 1'b0);
    step();
    idle_chk("rst_edge", 1'b0);
    rst = 1'b0;
    send_word(4'b1011, 0, -1, 0, 1'b0, 4'b0101);
    gap(1);
    send_word(4'b1100, 0, 0, 3, 1'b0, 4'b0000);
    gap(2);
    send_word(4'b1011, 0, -1, 0, 1'b0, 4'b0101);
    send_word(4'b0110, 0, -1, 0, 1'b1, 4'b0000);
    gap(1);
    load_valid = 1'b1;
    d = 4'b1010;
    step();
    load_valid = 1'b0;
    ser_ready = 1'b1;
    chk("mid_bit0", ser_out, 1'b1);
    step();
    chk("mid_bit1", ser_out, 1'b0);
    step();
    #2 rst = 1'b1;
    #1 idle_chk("mid_rst", 1'b0);
    step();
    idle_chk("mid_rst_edge", 1'b0);
    rst = 1'b0;
    send_word(4'b1111, 0, -1, 0, 1'b1, 4'b0000);
    gap(1);
    for (int k = 0; k < 24; k++) begin
      send_word(W'($urandom), 2, -1, 0, 1'b1, 4'b0000);
      if ($urandom_range(1, 0) == 1) gap(int'($urandom_range(2, 1)));
    end
    gap(1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
